// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver with glitch-filtered clock and 2-byte nibble history.
// Optional mid-frame watchdog: define PS2_WATCHDOG_EN.
module ps2_rx_frame #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy,
    output logic [3:0] first,
    output logic [3:0] second,
    output logic [3:0] third,
    output logic [3:0] fourth
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                state;
    state_t                state_n;
    logic                  clk_s1;
    logic                  clk_s2;
    logic                  dat_s1;
    logic                  dat_s2;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt;
    logic                  filt_q;
    logic                  fall;
    logic                  timeout;
    logic [2:0]            bit_cnt;
    logic [2:0]            bit_cnt_n;
    logic [7:0]            shift;
    logic [7:0]            shift_n;
    logic                  parity;
    logic                  parity_n;
    logic [7:0]            rx_data_n;
    logic [15:0]           hist;
    logic [15:0]           hist_n;
    logic                  valid_n;
    logic                  err_n;

    if (FILTER_LEN < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("ps2_rx_frame: FILTER_LEN and TIMEOUT_CYC must be >= 2");
    end

    // Synchronisers and filter idle high so reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            dat_s1  <= 1'b1;
            dat_s2  <= 1'b1;
            filt_sr <= '1;
            filt_q  <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            dat_s1  <= ps2_data;
            dat_s2  <= dat_s1;
            filt_sr <= {filt_sr[FILTER_LEN-2:0], clk_s2};
            filt_q  <= filt;
        end
    end

    always_comb begin
        filt = filt_q;
        if (&filt_sr) begin
            filt = 1'b1;
        end else if (~|filt_sr) begin
            filt = 1'b0;
        end
    end

    assign fall = filt_q & ~filt;

`ifdef PS2_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (rst || fall || state == IDLE) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout = (state != IDLE) && !fall &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        parity_n  = parity;
        rx_data_n = rx_data;
        hist_n    = hist;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_n   = DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                DATA: begin
                    shift_n = {dat_s2, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    parity_n = dat_s2;
                    state_n  = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (dat_s2 && ^{shift, parity}) begin
                        valid_n   = 1'b1;
                        rx_data_n = shift;
                        hist_n    = {hist[7:0], shift};
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (timeout) begin
            state_n = IDLE;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            parity   <= 1'b0;
            rx_data  <= 8'd0;
            hist     <= 16'd0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            parity   <= parity_n;
            rx_data  <= rx_data_n;
            hist     <= hist_n;
            rx_valid <= valid_n;
            rx_err   <= err_n;
            busy     <= (state_n != IDLE);
        end
    end

    assign first  = hist[15:12];
    assign second = hist[11:8];
    assign third  = hist[7:4];
    assign fourth = hist[3:0];

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Randomised frame bench for ps2_rx_frame against a byte-level reference model.
module tb_ps2_rx_frame;

    localparam int FL  = 8;
    localparam int TO  = 1000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       busy;
    logic [3:0] first;
    logic [3:0] second;
    logic [3:0] third;
    logic [3:0] fourth;

    ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .busy(busy), .first(first), .second(second),
        .third(third), .fourth(fourth)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int nv = 0;
    int ne = 0;
    int n_both = 0;
    int exp_nv = 0;
    int exp_ne = 0;
    logic [7:0]  exp_data = 8'd0;
    logic [15:0] exp_hist = 16'd0;

    always @(negedge clk) begin
        if (rx_valid) nv++;
        if (rx_err) ne++;
        if (rx_valid && rx_err) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    // Sends bits f[0..n-1]; optional 5-cycle low glitch in the high phase of bit g.
    task automatic send_bits(input logic [10:0] f, input int n, input int g);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            if (i == g) begin
                cyc(8);
                ps2_clk = 1'b0;
                cyc(5);
                ps2_clk = 1'b1;
                cyc(HALF - 13);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input bit par_bad,
                         input bit stp, input int g);
        logic par;
        bit   good;
        par = (($countones(d) % 2) == 0) ^ par_bad;
        send_bits(mk(d, par, stp), 11, g);
        ps2_data = 1'b1;
        cyc(2 * HALF);
        good = stp && (($countones({d, par}) % 2) == 1);
        if (good) begin
            exp_nv++;
            exp_data = d;
            exp_hist = {exp_hist[7:0], d};
        end else begin
            exp_ne++;
        end
        chk({tag, "_valid_cnt"}, nv, exp_nv);
        chk({tag, "_err_cnt"}, ne, exp_ne);
        chk({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, exp_data});
        chk({tag, "_nibbles"}, {16'd0, first, second, third, fourth}, {16'd0, exp_hist});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int t;
        int lowcnt;
        logic [7:0] d;
        int r;
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cyc(4);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {30'd0, rx_valid, rx_err}, 32'd0);
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_nib", {16'd0, first, second, third, fourth}, 32'd0);
        rst = 1'b0;
        cyc(20);

        frame("t1", 8'h1C, 0, 1, -1);
        frame("t2a", 8'hF0, 0, 1, -1);
        frame("t2b", 8'h1C, 0, 1, -1);
        chk("t2_nib", {16'd0, first, second, third, fourth}, 32'h0000F01C);
        frame("t3par", 8'h1C, 1, 1, -1);
        frame("t3stop", 8'h1C, 0, 0, -1);

        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(20);
        chk("t4_idle_glitch_busy", {31'd0, busy}, 32'd0);
        frame("t4glitch", 8'h55, 0, 1, 4);
        frame("t4clean", 8'h55, 0, 1, -1);

        send_bits(mk(8'hA3, 1'b1, 1'b1), 5, -1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        exp_data = 8'd0;
        exp_hist = 16'd0;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_data", {24'd0, rx_data}, 32'd0);
        chk("t5_nib", {16'd0, first, second, third, fourth}, 32'd0);
        ps2_data = 1'b1;
        cyc(40);
        frame("t5", 8'hA3, 0, 1, -1);
        chk("t5_nib_a3", {16'd0, first, second, third, fourth}, 32'h000000A3);

        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            frame($sformatf("rnd%0d", i), d, r == 0, r != 1, -1);
        end

        send_bits(mk(8'h6B, 1'b0, 1'b1), 5, -1);
        ps2_data = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b0;
`ifdef PS2_WATCHDOG_EN
        t = 0;
        while (!rx_err && t < 3000) begin
            cyc(1);
            t++;
            if (t == HALF) ps2_clk = 1'b1;
        end
        exp_ne++;
        chk("t6_wd_latency", t, 2 + FL + 1 + TO);
        chk("t6_wd_busy", {31'd0, busy}, 32'd0);
        cyc(5);
        chk("t6_wd_err_cnt", ne, exp_ne);
        chk("t6_wd_valid_cnt", nv, exp_nv);
`else
        lowcnt = 0;
        t = 0;
        for (int i = 0; i < 5000; i++) begin
            cyc(1);
            if (i == HALF) ps2_clk = 1'b1;
            if (i > 2 + FL + 2 && !busy) lowcnt++;
        end
        chk("t6_busy_low_cycles", lowcnt, 0);
        chk("t6_busy_end", {31'd0, busy}, 32'd1);
        chk("t6_err_cnt", ne, exp_ne);
        chk("t6_valid_cnt", nv, exp_nv);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
`endif
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cyc(20);
        chk("never_both", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
